// File: rtl/alu_op_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_scheduler_if
// Description : Requester, ALU and response signals of the ALU op scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_op_scheduler_if #(
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic              req0_ready;
    logic [5:0]        req0_opcode;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic              req1_valid;
    logic              req1_ready;
    logic [5:0]        req1_opcode;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [5:0]        alu_opcode;
    logic [DATA_W-1:0] alu_ans1;
    logic              alu_ans2;
    logic              alu_z;
    logic              alu_n;
    logic              resp_valid;
    logic              resp_ready;
    logic              resp_id;
    logic [DATA_W-1:0] resp_result;
    logic              resp_err;
    logic              flag_c;
    logic              flag_z;
    logic              flag_n;
    logic              busy;

    // Environment side: requesters, the ALU itself and the response consumer.
    modport master (
        output req0_valid, req0_opcode, req0_a, req0_b,
        output req1_valid, req1_opcode, req1_a, req1_b,
        output alu_ans1, alu_ans2, alu_z, alu_n, resp_ready,
        input  req0_ready, req1_ready, alu_a, alu_b, alu_opcode,
        input  resp_valid, resp_id, resp_result, resp_err,
        input  flag_c, flag_z, flag_n, busy
    );

    modport slave (
        input  req0_valid, req0_opcode, req0_a, req0_b,
        input  req1_valid, req1_opcode, req1_a, req1_b,
        input  alu_ans1, alu_ans2, alu_z, alu_n, resp_ready,
        output req0_ready, req1_ready, alu_a, alu_b, alu_opcode,
        output resp_valid, resp_id, resp_result, resp_err,
        output flag_c, flag_z, flag_n, busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_scheduler
// Description : Round-robin sharing of one combinational ALU by two requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_scheduler #(
    parameter int DATA_W        = 32,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    alu_op_scheduler_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] c_CNT_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [5:0] c_OP_ADD = 6'b010000;
    localparam logic [5:0] c_OP_SUB = 6'b010001;
    localparam logic [5:0] c_OP_EQ  = 6'b100000;
    localparam logic [5:0] c_OP_NE  = 6'b100001;
    localparam logic [5:0] c_OP_LE  = 6'b100010;
    localparam logic [5:0] c_OP_GT  = 6'b100011;
    localparam logic [5:0] c_OP_SLL = 6'b110000;
    localparam logic [5:0] c_OP_SRL = 6'b110001;
    localparam logic [5:0] c_OP_SRA = 6'b110010;

    function automatic logic op_supported(input logic [5:0] op);
        case (op)
            c_OP_ADD, c_OP_SUB, c_OP_EQ, c_OP_NE, c_OP_LE, c_OP_GT,
            c_OP_SLL, c_OP_SRL, c_OP_SRA: op_supported = 1'b1;
            default:                      op_supported = 1'b0;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [5:0]        alu_op_q, alu_op_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_id_q, resp_id_d;
    logic [DATA_W-1:0] resp_result_q, resp_result_d;
    logic              resp_err_q, resp_err_d;
    logic              flag_c_q, flag_c_d;
    logic              flag_z_q, flag_z_d;
    logic              flag_n_q, flag_n_d;

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_idle;
    logic [5:0]        w_op_sel;
    logic [DATA_W-1:0] w_a_sel;
    logic [DATA_W-1:0] w_b_sel;
    logic              w_addsub;

    // On contention the requester that did not win last time is granted.
    assign w_gnt0   = bus.req0_valid & (~bus.req1_valid | last_grant_q);
    assign w_gnt1   = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
    assign w_idle   = (state_q == IDLE);
    assign w_op_sel = w_gnt1 ? bus.req1_opcode : bus.req0_opcode;
    assign w_a_sel  = w_gnt1 ? bus.req1_a      : bus.req0_a;
    assign w_b_sel  = w_gnt1 ? bus.req1_b      : bus.req0_b;
    assign w_addsub = (alu_op_q == c_OP_ADD) | (alu_op_q == c_OP_SUB);

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_op_d      = alu_op_q;
        resp_valid_d  = resp_valid_q;
        resp_id_d     = resp_id_q;
        resp_result_d = resp_result_q;
        resp_err_d    = resp_err_q;
        flag_c_d      = flag_c_q;
        flag_z_d      = flag_z_q;
        flag_n_d      = flag_n_q;
        case (state_q)
            IDLE: begin
                if (w_gnt0 | w_gnt1) begin
                    last_grant_d = w_gnt1;
                    resp_id_d    = w_gnt1;
                    if (op_supported(w_op_sel)) begin
                        alu_op_d = w_op_sel;
                        alu_a_d  = w_a_sel;
                        alu_b_d  = w_b_sel;
                        cnt_d    = c_CNT_LOAD;
                        state_d  = SETTLE;
                    end else begin
                        resp_err_d    = 1'b1;
                        resp_result_d = '0;
                        resp_valid_d  = 1'b1;
                        state_d       = RESP;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == 4'd0) begin
                    resp_result_d = bus.alu_ans1;
                    resp_err_d    = 1'b0;
                    flag_z_d      = bus.alu_z;
                    flag_n_d      = bus.alu_n;
                    if (w_addsub) begin
                        flag_c_d = bus.alu_ans2;
                    end
                    resp_valid_d  = 1'b1;
                    state_d       = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            cnt_q         <= 4'd0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= 6'd0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= 1'b0;
            resp_result_q <= '0;
            resp_err_q    <= 1'b0;
            flag_c_q      <= 1'b0;
            flag_z_q      <= 1'b0;
            flag_n_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_op_q      <= alu_op_d;
            resp_valid_q  <= resp_valid_d;
            resp_id_q     <= resp_id_d;
            resp_result_q <= resp_result_d;
            resp_err_q    <= resp_err_d;
            flag_c_q      <= flag_c_d;
            flag_z_q      <= flag_z_d;
            flag_n_q      <= flag_n_d;
        end
    end

    // Ready is gated by reset so every output reads 0 while rst is held.
    assign bus.req0_ready  = w_idle & w_gnt0 & ~rst;
    assign bus.req1_ready  = w_idle & w_gnt1 & ~rst;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_opcode  = alu_op_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_id     = resp_id_q;
    assign bus.resp_result = resp_result_q;
    assign bus.resp_err    = resp_err_q;
    assign bus.flag_c      = flag_c_q;
    assign bus.flag_z      = flag_z_q;
    assign bus.flag_n      = flag_n_q;
    assign bus.busy        = ~w_idle;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_op_scheduler
// Description : Self-checking bench for alu_op_scheduler (SETTLE 1 and 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_op_scheduler_if #(.DATA_W(32)) sig1 ();
    alu_op_scheduler_if #(.DATA_W(32)) sig3 ();

    alu_op_scheduler #(.DATA_W(32), .SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(sig1.slave));
    alu_op_scheduler #(.DATA_W(32), .SETTLE_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(sig3.slave));

    int total = 0;
    int bad   = 0;

    // Behavioural ALU: {carry/borrow, result}; comparisons are unsigned.
    function automatic logic [32:0] alu_fn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            6'b010000: return {1'b0, a} + {1'b0, b};
            6'b010001: return {(a < b), a - b};
            6'b100000: return {32'd0, (a == b)};
            6'b100001: return {32'd0, (a != b)};
            6'b100010: return {32'd0, (a <= b)};
            6'b100011: return {32'd0, (a > b)};
            6'b110000: return {1'b0, a << b[4:0]};
            6'b110001: return {1'b0, a >> b[4:0]};
            6'b110010: return {1'b0, 32'($signed(a) >>> b[4:0])};
            default:   return 33'd0;
        endcase
    endfunction

    function automatic bit supported(input logic [5:0] op);
        return op inside {6'b010000, 6'b010001, 6'b100000, 6'b100001, 6'b100010,
                          6'b100011, 6'b110000, 6'b110001, 6'b110010};
    endfunction

    logic [32:0] alu1_r, alu3_r;
    assign alu1_r        = alu_fn(sig1.alu_opcode, sig1.alu_a, sig1.alu_b);
    assign sig1.alu_ans1 = alu1_r[31:0];
    assign sig1.alu_ans2 = alu1_r[32];
    assign sig1.alu_z    = (alu1_r[31:0] == 32'd0);
    assign sig1.alu_n    = alu1_r[31];
    assign alu3_r        = alu_fn(sig3.alu_opcode, sig3.alu_a, sig3.alu_b);
    assign sig3.alu_ans1 = alu3_r[31:0];
    assign sig3.alu_ans2 = alu3_r[32];
    assign sig3.alu_z    = (alu3_r[31:0] == 32'd0);
    assign sig3.alu_n    = alu3_r[31];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit v0, input bit v1,
                         input logic [5:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic [5:0] op1, input logic [31:0] a1, input logic [31:0] b1);
        sig1.req0_valid = v0; sig1.req0_opcode = op0; sig1.req0_a = a0; sig1.req0_b = b0;
        sig1.req1_valid = v1; sig1.req1_opcode = op1; sig1.req1_a = a1; sig1.req1_b = b1;
    endtask

    // Called at a negedge; returns at the negedge just after the accept edge.
    task automatic wait_accept(output bit gid, output bit ok);
        gid = 1'b0;
        ok  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (sig1.req0_ready || sig1.req1_ready) begin
                check("ready_onehot", {31'd0, sig1.req0_ready & sig1.req1_ready}, 32'd0);
                gid = sig1.req1_ready;
                ok  = 1'b1;
                @(negedge clk);
                sig1.req0_valid = 1'b0;
                sig1.req1_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        sig1.req0_valid = 1'b0;
        sig1.req1_valid = 1'b0;
        total++;
        bad++;
        $display("FAIL accept_timeout: got no ready expected ready within 20 cycles");
    endtask

    // Cycles from the accept edge until resp_valid is observed.
    task automatic wait_resp(output int lat);
        lat = 1;
        #1;
        while (!sig1.resp_valid && lat < 30) begin
            @(negedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic finish_resp(input int stall);
        if (stall > 0) begin
            sig1.resp_ready = 1'b0;
            repeat (stall) @(negedge clk);
        end
        sig1.resp_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_cmd(input string tag, input bit v0, input bit v1,
                           input logic [5:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                           input logic [5:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                           input int stall, input bit exp_id, input int exp_lat, input bit exp_err,
                           input logic [31:0] exp_res, input logic [2:0] exp_czn);
        bit gid, ok;
        int lat;
        drive(v0, v1, op0, a0, b0, op1, a1, b1);
        wait_accept(gid, ok);
        if (!ok) return;
        check({tag, "_grant"}, {31'd0, gid}, {31'd0, exp_id});
        wait_resp(lat);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_id"}, {31'd0, sig1.resp_id}, {31'd0, exp_id});
        check({tag, "_err"}, {31'd0, sig1.resp_err}, {31'd0, exp_err});
        check({tag, "_result"}, sig1.resp_result, exp_res);
        check({tag, "_flags_czn"}, {29'd0, sig1.flag_c, sig1.flag_z, sig1.flag_n}, {29'd0, exp_czn});
        check({tag, "_busy"}, {31'd0, sig1.busy}, 32'd1);
        finish_resp(stall);
    endtask

    typedef struct {
        bit          id;
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        bit          err;
        logic [31:0] res;
        logic [2:0]  czn;
    } vec_t;

    vec_t        tbl[12];
    logic [5:0]  ops[9] = '{6'b010000, 6'b010001, 6'b100000, 6'b100001, 6'b100010,
                            6'b100011, 6'b110000, 6'b110001, 6'b110010};
    bit          grants[4];
    logic [31:0] last_a;
    logic [5:0]  last_op;

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          gid, ok, prev, seen, m_last, m_c, m_z, m_n, sup, eid;
        int          lat, n, consec;
        logic [5:0]  rop0, rop1, eop;
        logic [31:0] ra0, rb0, ra1, rb1, ea, eb, eres;
        logic [32:0] r;

        tbl[0]  = '{0, 6'b010000, 32'hFFFF_FFFF, 32'd1,  0, 32'h0000_0000, 3'b110};
        tbl[1]  = '{1, 6'b111111, 32'd5,         32'd6,  1, 32'h0000_0000, 3'b110};
        tbl[2]  = '{0, 6'b010001, 32'd5,         32'd7,  0, 32'hFFFF_FFFE, 3'b101};
        tbl[3]  = '{1, 6'b100000, 32'd9,         32'd9,  0, 32'h0000_0001, 3'b100};
        tbl[4]  = '{0, 6'b010000, 32'd1,         32'd2,  0, 32'h0000_0003, 3'b000};
        tbl[5]  = '{1, 6'b100011, 32'd3,         32'd5,  0, 32'h0000_0000, 3'b010};
        tbl[6]  = '{0, 6'b110010, 32'h8000_0000, 32'd4,  0, 32'hF800_0000, 3'b001};
        tbl[7]  = '{1, 6'b110001, 32'h8000_0000, 32'd4,  0, 32'h0800_0000, 3'b000};
        tbl[8]  = '{0, 6'b110000, 32'd1,         32'd31, 0, 32'h8000_0000, 3'b001};
        tbl[9]  = '{1, 6'b100001, 32'd4,         32'd4,  0, 32'h0000_0000, 3'b010};
        tbl[10] = '{0, 6'b100010, 32'd4,         32'd4,  0, 32'h0000_0001, 3'b000};
        tbl[11] = '{0, 6'b010010, 32'd7,         32'd7,  1, 32'h0000_0000, 3'b000};

        drive(1, 1, 6'b010000, 32'd1, 32'd1, 6'b010000, 32'd2, 32'd2);
        sig1.resp_ready = 1'b1;
        sig3.req0_valid = 1'b0; sig3.req0_opcode = 6'd0; sig3.req0_a = 32'd0; sig3.req0_b = 32'd0;
        sig3.req1_valid = 1'b0; sig3.req1_opcode = 6'd0; sig3.req1_a = 32'd0; sig3.req1_b = 32'd0;
        sig3.resp_ready = 1'b1;

        // Reset state with both requesters valid: every output must read 0.
        #2;
        check("rst_ready", {30'd0, sig1.req0_ready, sig1.req1_ready}, 32'd0);
        check("rst_alu_a_b", sig1.alu_a | sig1.alu_b, 32'd0);
        check("rst_alu_op", {26'd0, sig1.alu_opcode}, 32'd0);
        check("rst_resp", {30'd0, sig1.resp_valid, sig1.resp_err} | sig1.resp_result | {31'd0, sig1.resp_id}, 32'd0);
        check("rst_flags_busy", {28'd0, sig1.flag_c, sig1.flag_z, sig1.flag_n, sig1.busy}, 32'd0);
        sig1.req0_valid = 1'b0;
        sig1.req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // SETTLE_CYCLES=3: add to set flag_c, then sll with a held ALU window.
        sig3.req0_valid = 1'b1; sig3.req0_opcode = 6'b010000; sig3.req0_a = 32'hFFFF_FFFF; sig3.req0_b = 32'd1;
        #1;
        check("s3_ready", {31'd0, sig3.req0_ready}, 32'd1);
        @(negedge clk);
        sig3.req0_valid = 1'b0;
        lat = 1;
        #1;
        while (!sig3.resp_valid && lat < 30) begin @(negedge clk); #1; lat++; end
        check("s3_add_latency", lat, 32'd4);
        check("s3_add_flag_c", {31'd0, sig3.flag_c}, 32'd1);
        @(negedge clk);
        sig3.req0_valid = 1'b1; sig3.req0_opcode = 6'b110000; sig3.req0_a = 32'd1; sig3.req0_b = 32'd4;
        @(negedge clk);
        sig3.req0_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            #1;
            check("s3_alu_a", sig3.alu_a, 32'd1);
            check("s3_alu_b", sig3.alu_b, 32'd4);
            check("s3_alu_op", {26'd0, sig3.alu_opcode}, 32'h30);
            check("s3_no_early_resp", {31'd0, sig3.resp_valid}, 32'd0);
            @(negedge clk);
        end
        #1;
        check("s3_sll_valid", {31'd0, sig3.resp_valid}, 32'd1);
        check("s3_sll_result", sig3.resp_result, 32'd16);
        check("s3_sll_flag_c", {31'd0, sig3.flag_c}, 32'd1);

        // Round-robin contention: both requesters held valid for four grants.
        @(negedge clk);
        drive(1, 1, 6'b010000, 32'd1, 32'd1, 6'b010000, 32'd2, 32'd2);
        n = 0; prev = 1'b0; consec = 0;
        for (int i = 0; i < 100 && n < 4; i++) begin
            #1;
            if (sig1.req0_ready || sig1.req1_ready) begin
                check("rr_onehot", {31'd0, sig1.req0_ready & sig1.req1_ready}, 32'd0);
                if (prev) consec++;
                grants[n] = sig1.req1_ready;
                n++;
                prev = 1'b1;
            end else begin
                prev = 1'b0;
            end
            @(negedge clk);
        end
        sig1.req0_valid = 1'b0;
        sig1.req1_valid = 1'b0;
        #1;
        for (int i = 0; i < 10 && sig1.busy; i++) begin @(negedge clk); #1; end
        check("rr_count", n, 32'd4);
        check("rr_pulse_width", consec, 32'd0);
        for (int i = 0; i < 4; i++) check($sformatf("rr_grant%0d", i), {31'd0, grants[i]}, i % 2);
        @(negedge clk);

        // Table of single-requester commands, flags carried from row to row.
        for (int i = 0; i < 12; i++) begin
            run_cmd($sformatf("vec%0d", i), !tbl[i].id, tbl[i].id,
                    tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].a, tbl[i].b,
                    0, tbl[i].id, tbl[i].err ? 1 : 2, tbl[i].err, tbl[i].res, tbl[i].czn);
            if (!tbl[i].err) begin
                last_a  = tbl[i].a;
                last_op = tbl[i].op;
            end else begin
                check($sformatf("vec%0d_alu_a_kept", i), sig1.alu_a, last_a);
                check($sformatf("vec%0d_alu_op_kept", i), {26'd0, sig1.alu_opcode}, {26'd0, last_op});
            end
        end

        // Backpressure: five stalled cycles with both requesters knocking.
        sig1.resp_ready = 1'b0;
        drive(0, 1, 6'd0, 32'd0, 32'd0, 6'b010000, 32'd7, 32'd8);
        wait_accept(gid, ok);
        check("bp_grant", {31'd0, gid}, 32'd1);
        wait_resp(lat);
        check("bp_latency", lat, 32'd2);
        sig1.req0_valid = 1'b1;
        sig1.req1_valid = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_hold%0d", k),
                  {31'd0, sig1.resp_valid && sig1.resp_result == 32'd15 && sig1.resp_id && !sig1.resp_err
                          && sig1.busy && !sig1.req0_ready && !sig1.req1_ready}, 32'd1);
            @(negedge clk);
            #1;
        end
        sig1.resp_ready = 1'b1;
        #1;
        check("bp_handshake_no_ready", {30'd0, sig1.req0_ready, sig1.req1_ready}, 32'd0);
        @(negedge clk);
        #1;
        check("bp_idle_ready0", {30'd0, sig1.req0_ready, sig1.req1_ready}, 32'd2);
        check("bp_valid_cleared", {31'd0, sig1.resp_valid}, 32'd0);
        sig1.req0_valid = 1'b0;
        sig1.req1_valid = 1'b0;
        @(negedge clk);

        // Randomized commands against the reference model, from a fresh reset.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_last = 1'b1; m_c = 1'b0; m_z = 1'b0; m_n = 1'b0;
        for (int it = 0; it < 40; it++) begin
            int mode;
            mode = $urandom_range(0, 2);
            rop0 = ($urandom_range(0, 5) == 0) ? 6'($urandom) : ops[$urandom_range(0, 8)];
            rop1 = ($urandom_range(0, 5) == 0) ? 6'($urandom) : ops[$urandom_range(0, 8)];
            ra0 = $urandom; rb0 = $urandom; ra1 = $urandom; rb1 = $urandom;
            if (mode == 2) eid = ~m_last;
            else           eid = (mode == 1);
            eop = eid ? rop1 : rop0;
            ea  = eid ? ra1  : ra0;
            eb  = eid ? rb1  : rb0;
            sup = supported(eop);
            r   = alu_fn(eop, ea, eb);
            eres = sup ? r[31:0] : 32'd0;
            if (sup) begin
                m_z = (r[31:0] == 32'd0);
                m_n = r[31];
                if (eop == 6'b010000 || eop == 6'b010001) m_c = r[32];
            end
            m_last = eid;
            run_cmd($sformatf("rnd%0d", it), mode != 1, mode != 0, rop0, ra0, rb0, rop1, ra1, rb1,
                    $urandom_range(0, 3), eid, sup ? 2 : 1, !sup, eres, {m_c, m_z, m_n});
        end

        // Reset during SETTLE aborts the command and clears the flags.
        run_cmd("pre_rst", 1, 0, 6'b010000, 32'hFFFF_FFFF, 32'd1, 6'd0, 32'd0, 32'd0,
                0, 0, 2, 0, 32'd0, 3'b110);
        drive(1, 0, 6'b010000, 32'h1234, 32'd1, 6'd0, 32'd0, 32'd0);
        wait_accept(gid, ok);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_alu", sig1.alu_a | {26'd0, sig1.alu_opcode}, 32'd0);
        check("mid_rst_flags", {29'd0, sig1.flag_c, sig1.flag_z, sig1.flag_n}, 32'd0);
        check("mid_rst_busy_valid", {30'd0, sig1.busy, sig1.resp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (4) begin @(negedge clk); #1; seen |= sig1.resp_valid; end
        check("mid_rst_no_resp", {31'd0, seen}, 32'd0);
        @(negedge clk);
        run_cmd("post_rst", 1, 1, 6'b100001, 32'd3, 32'd4, 6'b100001, 32'd5, 32'd5,
                0, 0, 2, 0, 32'd1, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_op_scheduler.md
Name: alu_op_scheduler

Overview:
- Shares the single combinational 32-bit ALU between two independent command requesters.
- Arbitrates round-robin, decodes and validates the 6-bit opcode, and drives registered operands and opcode into the ALU.
- Holds those ALU inputs stable for a settle window, then captures the result and flags and returns a tagged response.
- Keeps architectural C/Z/N flag registers for the control unit.

Parameters:
DATA_W, 32, operand/result width; the ALU is 32-bit, so only 32 is supported.
SETTLE_CYCLES, 1, cycles ALU inputs are held before capture; legal range 1..15.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-high
req0_valid  in  1  requester 0 command valid
req0_ready  out  1  requester 0 command accepted (with valid)
req0_opcode  in  6  requester 0 ALU opcode
req0_a  in  DATA_W  requester 0 operand A
req0_b  in  DATA_W  requester 0 operand B / shift amount
req1_valid, req1_ready, req1_opcode, req1_a, req1_b  same as requester 0, for requester 1
alu_a  out  DATA_W  registered operand A to ALU
alu_b  out  DATA_W  registered operand B to ALU
alu_opcode  out  6  registered opcode to ALU
alu_ans1  in  DATA_W  ALU result
alu_ans2  in  1  ALU carry/borrow out
alu_z  in  1  ALU zero flag
alu_n  in  1  ALU negative flag
resp_valid  out  1  response valid
resp_ready  in  1  response consumer ready
resp_id  out  1  requester index of response
resp_result  out  DATA_W  captured result
resp_err  out  1  unsupported opcode
flag_c, flag_z, flag_n  out  1 each  architectural flags
busy  out  1  high when state != IDLE

Behaviour:
- Reset (async, active-high):
  - state=IDLE.
  - All outputs 0, including alu_*, resp_*, flags and ready.
  - last_grant=1, so requester 0 wins first.
  - Settle counter 0.
- Reset mid-operation aborts the operation: no response is issued and flags are cleared.
- Supported opcodes: 010000 add, 010001 sub, 100000 eq, 100001 ne, 100010 le, 100011 gt, 110000 sll, 110001 srl, 110010 sra. Any other value is unsupported.
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - If only one reqN_valid is high, grant it.
  - If both are high, grant the requester != last_grant.
  - reqN_ready is combinational: high only in IDLE, only for the granted requester. At most one ready is high per cycle.
  - Accept = valid & ready. On accept, update last_grant and register resp_id=N.
  - Supported opcode: register opcode/a/b into alu_opcode/alu_a/alu_b, load counter=SETTLE_CYCLES-1, go to SETTLE.
  - Unsupported opcode: alu_* unchanged, resp_err=1, resp_result=0, flags unchanged, go to RESP.
- SETTLE:
  - alu_* held constant.
  - Counter decrements each cycle.
  - At counter==0, capture: resp_result<=alu_ans1, resp_err<=0, flag_z<=alu_z, flag_n<=alu_n. Go to RESP.
  - flag_c<=alu_ans2 only for add/sub; otherwise flag_c is held.
- RESP:
  - resp_valid=1; resp_result, resp_id and resp_err are stable until resp_ready.
  - On resp_valid & resp_ready: resp_valid<=0, go to IDLE.
  - No new command is accepted in the handshake cycle.
- Latency:
  - Supported op: resp_valid is high SETTLE_CYCLES+1 cycles after the accept edge.
  - Error op: resp_valid is high 1 cycle after the accept edge.
  - Throughput: one command per SETTLE_CYCLES+2 cycles when resp_ready is tied high.
- Requesters may drop valid before ready; no requirement to retain a request.
- alu_b is passed unmodified for shifts; shift-amount interpretation belongs to the ALU.
- Flags only change at capture, at reset, or never (error path).

Test Plan:
- Reset then single add: req0 op=010000, a=32'hFFFFFFFF, b=1, resp_ready=1, SETTLE=1, ALU model gives ans1=0, ans2=1, z=1 -> resp_valid 2 cycles after accept; resp_result=0, resp_id=0, flag_c=1, flag_z=1, flag_n=0.
- Round-robin contention: req0 and req1 held valid for 4 commands -> grant order 0,1,0,1; each ready is a single-cycle pulse; never both ready in one cycle.
- Unsupported opcode 6'b111111 from req1 after an add that set flag_c=1 -> resp_err=1, resp_result=0, resp_valid 1 cycle after accept; alu_* unchanged; flag_c stays 1.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid -> result/id/err held stable, busy=1, req ready low; first ready after the handshake comes in the next IDLE cycle.
- SETTLE_CYCLES=3 with sll a=1, b=4 (model ans1=16) -> alu_* constant for 3 cycles; resp_result=16; flag_c unchanged.
- Reset mid-operation: assert rst during SETTLE -> outputs 0 immediately (async); no resp_valid afterward; next command is granted to req0.
